// File: rtl/screen_uart_dump_pkg.sv
// Shared constants and types for the screen dump reader and the text editor:
// ASCII control codes, FSM state types and the printable-character filter.
package screen_uart_dump_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_SEND_CHAR,
    ST_SEND_CR,
    ST_SEND_LF,
    ST_FINISH
  } dump_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_phase_e;

  // Tile codes below 0x20 are control characters; show them as a space so the
  // host terminal is never disturbed by stray cursor or bell codes.
  function automatic logic [7:0] printable(input logic [6:0] code);
    logic [7:0] ext;
    ext = {1'b0, code};
    return (ext < ASCII_SP) ? ASCII_SP : ext;
  endfunction

endpackage

// File: rtl/screen_uart_dump_uart_tx_byte.sv
// 8N1 UART byte transmitter, LSB first. tx_done pulses in the final cycle of
// the stop bit; a new tx_start is accepted in that same cycle so that bytes
// can follow back to back with no idle gap.
module uart_tx_byte
  import screen_uart_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_phase_e     phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          bit_end;
  logic          accept;

  assign bit_end = (cnt_q == CNT_LAST);
  assign tx_done = (phase_q == TX_STOP) && bit_end;
  assign accept  = tx_start && ((phase_q == TX_IDLE) || tx_done);
  assign tx      = tx_q;

  // State register; the line idles high out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Bit timing, shift-out sequencing and acceptance of the next byte.
  always_comb begin
    phase_d = phase_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    cnt_d   = bit_end ? '0 : cnt_q + CW'(1);

    unique case (phase_q)
      TX_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
      end
      TX_START: begin
        if (bit_end) begin
          phase_d = TX_DATA;
          bit_d   = 4'd0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_q == 4'd7) begin
            phase_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 4'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          phase_d = TX_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        phase_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (accept) begin
      phase_d = TX_START;
      cnt_d   = '0;
      bit_d   = 4'd0;
      shift_d = tx_byte;
      tx_d    = 1'b0;
    end
  end

endmodule

// File: rtl/screen_uart_dump.sv
// Screen dump reader: on a start tick walks the tile RAM row by row through
// its spare read port and streams every row over the UART, ending each row
// with CR LF. The RAM is only ever read.
module screen_uart_dump
  import screen_uart_dump_pkg::*;
#(
  parameter int MAX_X        = 40,
  parameter int MAX_Y        = 20,
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [11:0] rd_addr,
  input  logic [6:0]  rd_data,
  output logic        tx,
  output logic        busy,
  output logic        done_tick
);

  localparam logic [6:0] COL_LAST = 7'(MAX_X - 1);
  localparam logic [4:0] ROW_LAST = 5'(MAX_Y - 1);

  dump_state_e state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [11:0] addr_q, addr_d;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_done;

  // The live address is presented while a cell is being read; otherwise the
  // last fetched address is held so the port does not toggle during CR/LF.
  assign rd_addr   = ((state_q == ST_FETCH) || (state_q == ST_LATCH)) ?
                     {row_q, col_q} : addr_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign done_tick = (state_q == ST_FINISH);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (clk),
    .reset   (reset),
    .tx_start(tx_start),
    .tx_byte (tx_byte),
    .tx      (tx),
    .tx_done (tx_done)
  );

  // Control registers; a reset abandons any partial frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
    end
  end

  // Dump sequencing: fetch a cell, filter and send it, close rows with CR LF.
  // CR is loaded in the cycle the last character completes (and LF in the
  // cycle CR completes) so line endings follow with no idle gap.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    addr_d   = addr_q;
    tx_start = 1'b0;
    tx_byte  = ASCII_SP;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ST_FETCH: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        tx_start = 1'b1;
        tx_byte  = printable(rd_data);
        addr_d   = {row_q, col_q};
        state_d  = ST_SEND_CHAR;
      end
      ST_SEND_CHAR: begin
        if (tx_done) begin
          if (col_q < COL_LAST) begin
            col_d   = col_q + 7'd1;
            state_d = ST_FETCH;
          end else begin
            col_d    = '0;
            tx_start = 1'b1;
            tx_byte  = ASCII_CR;
            state_d  = ST_SEND_CR;
          end
        end
      end
      ST_SEND_CR: begin
        if (tx_done) begin
          tx_start = 1'b1;
          tx_byte  = ASCII_LF;
          state_d  = ST_SEND_LF;
        end
      end
      ST_SEND_LF: begin
        if (tx_done) begin
          if (row_q < ROW_LAST) begin
            row_d   = row_q + 5'd1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_screen_uart_dump.sv
// Bench for screen_uart_dump: small screen, fast baud, behavioural tile RAM,
// a cycle-sampling UART decoder and a byte-stream reference model.
module tb_screen_uart_dump;

  localparam int MX       = 4;
  localparam int MY       = 2;
  localparam int CPB      = 4;
  localparam int FRAME    = CPB * 10;
  localparam int NBYTES   = MY * (MX + 2);
  localparam int BUSY_EXP = NBYTES * FRAME + MY * MX * 2;
  localparam int LIMIT    = 5000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [11:0] rd_addr;
  logic [6:0]  rd_data;
  logic        tx, busy, done_tick;

  int checks = 0;
  int errors = 0;

  screen_uart_dump #(
    .MAX_X(MX), .MAX_Y(MY), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rd_addr(rd_addr),
    .rd_data(rd_data), .tx(tx), .busy(busy), .done_tick(done_tick)
  );

  always #5 clk = ~clk;

  // Tile RAM with a registered read port.
  logic [6:0] ram [0:4095];
  always @(posedge clk) rd_data <= ram[rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // UART decoder: samples tx every cycle across a whole frame.
  logic [7:0] rx_q [$];
  logic       tx_prev = 1'b1;
  logic       smp [0:FRAME-1];
  logic [7:0] rx_byte;
  logic       aborted;
  logic       level;
  int         bad;

  always begin
    @(posedge clk); #1;
    if (reset && tx_prev && !tx) begin
      smp[0] = tx;
      aborted = 1'b0;
      for (int j = 1; j < FRAME; j++) begin
        @(posedge clk); #1;
        if (!reset) begin
          aborted = 1'b1;
          break;
        end
        smp[j] = tx;
      end
      if (!aborted) begin
        rx_byte = 8'h00;
        for (int k = 0; k < 8; k++) rx_byte[k] = smp[(k + 1) * CPB + CPB / 2];
        bad = 0;
        for (int j = 0; j < FRAME; j++) begin
          if (j < CPB) level = 1'b0;
          else if (j >= 9 * CPB) level = 1'b1;
          else level = rx_byte[j / CPB - 1];
          if (smp[j] !== level) bad++;
        end
        check("frame_timing", bad, 0);
        rx_q.push_back(rx_byte);
      end
    end
    tx_prev = tx;
  end

  // Busy length, done pulses and the address sequence seen during a dump.
  int          busy_cnt = 0;
  int          last_busy_len = 0;
  logic        busy_prev = 1'b0;
  int          done_cnt = 0;
  logic [11:0] addr_log [$];

  always begin
    @(posedge clk); #1;
    if (!reset) begin
      busy_cnt  = 0;
      busy_prev = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      else if (busy_prev) begin
        last_busy_len = busy_cnt;
        busy_cnt = 0;
      end
      busy_prev = busy;
      if (done_tick) done_cnt++;
      if (busy && (addr_log.size() == 0 || addr_log[addr_log.size() - 1] != rd_addr))
        addr_log.push_back(rd_addr);
    end
  end

  // Reference model: the byte stream the host should receive.
  logic [7:0] exp_q [$];

  task automatic build_model();
    logic [7:0] b;
    exp_q.delete();
    for (int r = 0; r < MY; r++) begin
      for (int c = 0; c < MX; c++) begin
        b = {1'b0, ram[r * 128 + c]};
        if (b < 8'h20) b = 8'h20;
        exp_q.push_back(b);
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
  endtask

  // Pulse start, optionally pulse it again restart_at cycles later, wait for done.
  task automatic do_dump(input string tag, input int restart_at);
    int n;
    rx_q.delete();
    addr_log.delete();
    done_cnt = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < LIMIT) begin
      @(negedge clk);
      start = (restart_at != 0 && n == restart_at);
      n++;
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_busy_len"}, last_busy_len, BUSY_EXP);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_tx_idle"}, tx, 1'b1);
  endtask

  typedef struct packed {
    logic [63:0] cells;
    logic [95:0] exp;
  } vec_t;

  vec_t vecs [3];

  task automatic load_vec(input vec_t v);
    logic [7:0] t;
    for (int i = 0; i < MX * MY; i++) begin
      t = v.cells[63 - 8 * i -: 8];
      ram[(i / MX) * 128 + (i % MX)] = t[6:0];
    end
  endtask

  task automatic exp_from_vec(input vec_t v);
    exp_q.delete();
    for (int i = 0; i < NBYTES; i++) exp_q.push_back(v.exp[95 - 8 * i -: 8]);
  endtask

  initial begin
    vecs[0] = '{cells: 64'h41424344_7778797A, exp: 96'h41424344_0D0A_7778797A_0D0A};
    vecs[1] = '{cells: 64'h41004344_7778791F, exp: 96'h41204344_0D0A_77787920_0D0A};
    vecs[2] = '{cells: 64'h7F201F21_30017E19, exp: 96'h7F202021_0D0A_30207E20_0D0A};

    for (int i = 0; i < 4096; i++) ram[i] = 7'h20;

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done_tick, 1'b0);
    check("rst_addr", rd_addr, 12'h000);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);

    // Directed vectors.
    for (int t = 0; t < 3; t++) begin
      load_vec(vecs[t]);
      do_dump($sformatf("vec%0d", t), 0);
      exp_from_vec(vecs[t]);
      cmp_stream($sformatf("vec%0d", t));
      check($sformatf("vec%0d_addr_n", t), addr_log.size(), MX * MY);
      for (int i = 0; i < MX * MY && i < addr_log.size(); i++)
        check($sformatf("vec%0d_addr%0d", t, i), addr_log[i], (i / MX) * 128 + (i % MX));
    end

    // Random screen contents against the reference model.
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < MY; r++)
        for (int c = 0; c < MX; c++)
          ram[r * 128 + c] = 7'($urandom_range(0, 127));
      build_model();
      do_dump($sformatf("rnd%0d", k), 0);
      cmp_stream($sformatf("rnd%0d", k));
    end

    // Start pulsed again mid-dump is ignored, not queued.
    load_vec(vecs[0]);
    do_dump("restart", 50);
    exp_from_vec(vecs[0]);
    cmp_stream("restart");

    // Reset in the middle of byte 5 (the first CR).
    begin
      int n;
      rx_q.delete();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      n = 0;
      while (rx_q.size() < 4 && n < LIMIT) begin
        @(posedge clk);
        n++;
      end
      check("rst_mid_reached", (rx_q.size() >= 4), 1'b1);
      repeat (15) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("rst_mid_tx", tx, 1'b1);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_done", done_tick, 1'b0);
      check("rst_mid_addr", rd_addr, 12'h000);
      repeat (3) @(negedge clk);
      check("rst_hold_tx", tx, 1'b1);
      check("rst_hold_busy", busy, 1'b0);
      check("rst_partial_bytes", rx_q.size(), 4);
      @(negedge clk) reset = 1'b1;
      repeat (3) @(negedge clk);
      do_dump("after_rst", 0);
      exp_from_vec(vecs[0]);
      cmp_stream("after_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
